// File: rtl/nw_seq_scheduler.sv
// Read scheduler for the Needleman-Wunsch sequence RAMs.
// The fill scan walks (i,j) in row-major order and presents each character
// pair over valid/ready. While idle it serves single traceback pair reads.
module nw_seq_scheduler #(
  parameter int N    = 128,
  parameter int M    = 128,
  parameter int BitA = $clog2(N),
  parameter int BitB = $clog2(M)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [BitA-1:0] addr_a,
  output logic            en_a,
  input  logic [8:0]      dout_a,
  output logic [BitB-1:0] addr_b,
  output logic            en_b,
  input  logic [8:0]      dout_b,
  output logic            pair_valid,
  input  logic            pair_ready,
  output logic [BitA-1:0] pair_i,
  output logic [BitB-1:0] pair_j,
  output logic [8:0]      char_a,
  output logic [8:0]      char_b,
  input  logic            tb_req,
  input  logic [BitA-1:0] tb_i,
  input  logic [BitB-1:0] tb_j,
  output logic            tb_ack
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_PRESENT,
    S_DONE,
    S_TB_ISSUE,
    S_TB_CAPTURE,
    S_TB_ACK
  } state_t;

  localparam logic [BitA-1:0] LAST_I = BitA'(N - 1);
  localparam logic [BitB-1:0] LAST_J = BitB'(M - 1);

  state_t          r_state;
  logic [BitA-1:0] r_i;
  logic [BitB-1:0] r_j;
  logic [BitA-1:0] r_addr_a;
  logic [BitB-1:0] r_addr_b;
  logic            r_en;
  logic            r_busy;
  logic            r_done;
  logic            r_pair_valid;
  logic [BitA-1:0] r_pair_i;
  logic [BitB-1:0] r_pair_j;
  logic [8:0]      r_char_a;
  logic [8:0]      r_char_b;
  logic            r_tb_ack;

  // Outputs are registered and loaded together with the transition into the
  // state that owns them, so they are valid for exactly that state's cycles.
  // The traceback address is latched straight into the RAM address registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_i          <= '0;
      r_j          <= '0;
      r_addr_a     <= '0;
      r_addr_b     <= '0;
      r_en         <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pair_valid <= 1'b0;
      r_pair_i     <= '0;
      r_pair_j     <= '0;
      r_char_a     <= '0;
      r_char_b     <= '0;
      r_tb_ack     <= 1'b0;
    end else begin
      r_en         <= 1'b0;
      r_addr_a     <= '0;
      r_addr_b     <= '0;
      r_done       <= 1'b0;
      r_pair_valid <= 1'b0;
      r_pair_i     <= '0;
      r_pair_j     <= '0;
      r_tb_ack     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_i     <= '0;
            r_j     <= '0;
            r_en    <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_ISSUE;
          end else if (tb_req) begin
            r_addr_a <= tb_i;
            r_addr_b <= tb_j;
            r_en     <= 1'b1;
            r_state  <= S_TB_ISSUE;
          end
        end
        S_ISSUE: r_state <= S_CAPTURE;
        S_CAPTURE: begin
          r_char_a     <= dout_a;
          r_char_b     <= dout_b;
          r_pair_valid <= 1'b1;
          r_pair_i     <= r_i;
          r_pair_j     <= r_j;
          r_state      <= S_PRESENT;
        end
        S_PRESENT: begin
          if (!pair_ready) begin
            r_pair_valid <= 1'b1;
            r_pair_i     <= r_i;
            r_pair_j     <= r_j;
          end else if (r_i == LAST_I && r_j == LAST_J) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (r_j == LAST_J) begin
            r_i      <= r_i + 1'b1;
            r_j      <= '0;
            r_addr_a <= r_i + 1'b1;
            r_en     <= 1'b1;
            r_state  <= S_ISSUE;
          end else begin
            r_j      <= r_j + 1'b1;
            r_addr_a <= r_i;
            r_addr_b <= r_j + 1'b1;
            r_en     <= 1'b1;
            r_state  <= S_ISSUE;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        S_TB_ISSUE: r_state <= S_TB_CAPTURE;
        S_TB_CAPTURE: begin
          r_char_a <= dout_a;
          r_char_b <= dout_b;
          r_tb_ack <= 1'b1;
          r_state  <= S_TB_ACK;
        end
        S_TB_ACK: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign addr_a     = r_addr_a;
  assign addr_b     = r_addr_b;
  assign en_a       = r_en;
  assign en_b       = r_en;
  assign pair_valid = r_pair_valid;
  assign pair_i     = r_pair_i;
  assign pair_j     = r_pair_j;
  assign char_a     = r_char_a;
  assign char_b     = r_char_b;
  assign tb_ack     = r_tb_ack;

endmodule

// File: tb/tb_nw_seq_scheduler.sv
// Bench for nw_seq_scheduler: RAM models, a queue-based model of the fill
// scan order, and a table of traceback reads with hand-derived characters.
module tb_nw_seq_scheduler;
  localparam int N  = 5;
  localparam int M  = 4;
  localparam int BA = $clog2(N);
  localparam int BB = $clog2(M);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          pair_ready = 1'b0;
  logic          tb_req = 1'b0;
  logic [BA-1:0] tb_i = '0;
  logic [BB-1:0] tb_j = '0;
  logic          busy, done, en_a, en_b, pair_valid, tb_ack;
  logic [BA-1:0] addr_a, pair_i;
  logic [BB-1:0] addr_b, pair_j;
  logic [8:0]    dout_a = '0;
  logic [8:0]    dout_b = '0;
  logic [8:0]    char_a, char_b;

  logic [8:0] mem_a [N];
  logic [8:0] mem_b [M];

  nw_seq_scheduler #(.N(N), .M(M)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .addr_a(addr_a), .en_a(en_a), .dout_a(dout_a),
    .addr_b(addr_b), .en_b(en_b), .dout_b(dout_b),
    .pair_valid(pair_valid), .pair_ready(pair_ready),
    .pair_i(pair_i), .pair_j(pair_j), .char_a(char_a), .char_b(char_b),
    .tb_req(tb_req), .tb_i(tb_i), .tb_j(tb_j), .tb_ack(tb_ack)
  );

  always #5 clk = ~clk;

  // Registered, enable-gated RAM reads
  always @(posedge clk) begin
    if (en_a) dout_a <= mem_a[addr_a];
    if (en_b) dout_b <= mem_b[addr_b];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int i;
    int j;
  } pair_t;

  typedef struct {
    int         ti;
    int         tj;
    logic [8:0] ea;
    logic [8:0] eb;
  } tbvec_t;

  // ready_mode: 0 = always ready, 1 = random, 2 = stall 5 cycles at (1,2)
  task automatic run_scan(input int ready_mode, input bit mid_start, input bit do_reset,
                          input bit with_tb, output int done_cycle);
    pair_t q[$];
    int    stall = 0;
    int    seen12 = 0;
    int    npairs = 0;
    bit    fin = 1'b0;
    bit    restarted = 1'b0;
    done_cycle = -1;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < M; j++) q.push_back('{i, j});
    start = 1'b1;
    if (with_tb) begin
      tb_req = 1'b1;
      tb_i   = '0;
      tb_j   = '0;
    end
    pair_ready = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 4000 && !fin; c++) begin
      if (do_reset && pair_valid && q.size() > 0 && q[0].i == 2 && q[0].j == 1) begin
        rst = 1'b0;
        step();
        chk("rst_busy", busy, 0);
        chk("rst_pair_valid", pair_valid, 0);
        chk("rst_en_a", en_a, 0);
        chk("rst_en_b", en_b, 0);
        chk("rst_char_a", char_a, 0);
        chk("rst_char_b", char_b, 0);
        chk("rst_done", done, 0);
        rst = 1'b1;
        step();
        chk("rst_stays_idle", busy, 0);
        return;
      end
      chk("busy_in_scan", busy, 1);
      chk("no_tb_ack_in_scan", tb_ack, 0);
      chk("en_not_in_present", en_a & pair_valid, 0);
      chk("en_a_eq_en_b", en_a, en_b);
      if (en_a && q.size() > 0) begin
        chk("issue_addr_a", addr_a, q[0].i);
        chk("issue_addr_b", addr_b, q[0].j);
      end
      if (ready_mode == 1) pair_ready = 1'($urandom_range(0, 1));
      else if (ready_mode == 2 && pair_valid && q.size() > 0 && q[0].i == 1 && q[0].j == 2
               && stall < 5) begin
        pair_ready = 1'b0;
        stall++;
      end else pair_ready = 1'b1;
      chk("pair_valid_expected", pair_valid, q.size() != 0 ? pair_valid : 1'b0);
      if (pair_valid && q.size() > 0) begin
        if (q[0].i == 1 && q[0].j == 2) seen12++;
        chk("pair_i", pair_i, q[0].i);
        chk("pair_j", pair_j, q[0].j);
        chk("char_a", char_a, mem_a[q[0].i]);
        chk("char_b", char_b, mem_b[q[0].j]);
        if (pair_ready) begin
          void'(q.pop_front());
          npairs++;
        end
      end
      if (mid_start && !restarted && pair_valid && q.size() > 0 && q[0].i == 3 && q[0].j == 0) begin
        start = 1'b1;
        restarted = 1'b1;
      end else start = 1'b0;
      if (done) begin
        chk("done_after_last_pair", q.size(), 0);
        done_cycle = c;
        fin = 1'b1;
      end
      step();
    end
    start = 1'b0;
    chk("scan_finished", fin, 1);
    chk("pair_count", npairs, N * M);
    chk("done_one_cycle", done, 0);
    chk("busy_cleared", busy, 0);
    if (ready_mode == 2) chk("stall_hold_cycles", seen12, 6);
  endtask

  task automatic tb_read(input int ti, input int tj, input logic [8:0] ea, input logic [8:0] eb);
    tb_req = 1'b1;
    tb_i   = BA'(ti);
    tb_j   = BB'(tj);
    step();
    chk("tb_en_a", en_a, 1);
    chk("tb_addr_a", addr_a, ti);
    chk("tb_addr_b", addr_b, tj);
    chk("tb_ack_early1", tb_ack, 0);
    step();
    chk("tb_ack_early2", tb_ack, 0);
    step();
    chk("tb_ack", tb_ack, 1);
    chk("tb_char_a", char_a, ea);
    chk("tb_char_b", char_b, eb);
    chk("tb_busy", busy, 0);
    tb_req = 1'b0;
    step();
    chk("tb_ack_pulse", tb_ack, 0);
  endtask

  initial begin
    tbvec_t vec[6];
    int     dc;
    int     wait_c;
    vec[0] = '{3, 1, 9'h054, 9'h041};
    vec[1] = '{0, 0, 9'h043, 9'h047};
    vec[2] = '{4, 3, 9'h047, 9'h043};
    vec[3] = '{1, 2, 9'h041, 9'h054};
    vec[4] = '{2, 0, 9'h043, 9'h047};
    vec[5] = '{4, 1, 9'h047, 9'h041};
    mem_a[0] = 9'h043; mem_a[1] = 9'h041; mem_a[2] = 9'h043; mem_a[3] = 9'h054; mem_a[4] = 9'h047;
    mem_b[0] = 9'h047; mem_b[1] = 9'h041; mem_b[2] = 9'h054; mem_b[3] = 9'h043;

    rst = 1'b0;
    step();
    step();
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_en", {en_a, en_b}, 0);
    chk("reset_addr", {addr_a, addr_b}, 0);
    chk("reset_pair_valid", pair_valid, 0);
    chk("reset_tb_ack", tb_ack, 0);
    chk("reset_chars", {char_a, char_b}, 0);
    rst = 1'b1;
    step();

    // Full scan, ready tied high
    run_scan(0, 1'b0, 1'b0, 1'b0, dc);
    chk("done_latency", dc, 60);

    // Traceback reads from the table
    for (int k = 0; k < 6; k++) tb_read(vec[k].ti, vec[k].tj, vec[k].ea, vec[k].eb);

    // Backpressure at (1,2)
    run_scan(2, 1'b0, 1'b0, 1'b0, dc);
    chk("done_latency_stalled", dc, 65);

    // start and tb_req together: scan first, then the traceback read
    run_scan(0, 1'b0, 1'b0, 1'b1, dc);
    wait_c = 0;
    while (!tb_ack && wait_c < 10) begin
      step();
      wait_c++;
    end
    chk("tb_pending_served", tb_ack, 1);
    chk("tb_pending_char_a", char_a, 9'h043);
    chk("tb_pending_char_b", char_b, 9'h047);
    tb_req = 1'b0;
    step();
    chk("tb_pending_pulse", tb_ack, 0);

    // Reset at (2,1), then a fresh scan from (0,0)
    run_scan(0, 1'b0, 1'b1, 1'b0, dc);
    run_scan(0, 1'b0, 1'b0, 1'b0, dc);
    chk("done_latency_after_rst", dc, 60);

    // start during the scan is ignored, not queued
    run_scan(0, 1'b1, 1'b0, 1'b0, dc);
    chk("done_latency_mid_start", dc, 60);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("no_queued_start", busy, 0);
    end

    // Random contents, random backpressure, random traceback reads
    for (int k = 0; k < N; k++) mem_a[k] = 9'($urandom);
    for (int k = 0; k < M; k++) mem_b[k] = 9'($urandom);
    run_scan(1, 1'b0, 1'b0, 1'b0, dc);
    for (int k = 0; k < 20; k++) begin
      int ri;
      int rj;
      ri = $urandom_range(0, N - 1);
      rj = $urandom_range(0, M - 1);
      tb_read(ri, rj, mem_a[ri], mem_b[rj]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/nw_seq_scheduler.md
Name: nw_seq_scheduler

Overview:
Read scheduler for the two sequence RAMs (A, length N; B, length M) of the Needleman-Wunsch core.
- Fill phase: walks every (i,j) cell in row-major order, reads A[i] and B[j], and presents each character pair to the matrix-fill datapath over a valid/ready handshake.
- Idle phase: serves single random-access pair reads for the traceback unit.
- Sits between both RAMs (1-cycle registered read, enable-gated, 9-bit data) and the fill/traceback logic. It is the only driver of the RAMs' read address and enable.

Parameters:
N, 128, length of sequence A (number of RAM_A cells); N >= 2
M, 128, length of sequence B (number of RAM_B cells); M >= 2
BitA, $clog2(N), width of A address / row index
BitB, $clog2(M), width of B address / column index

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-low reset (sampled on rising edge of clk)
start  input  1  one-cycle pulse; begins fill scan when in IDLE
busy  output  1  high from the cycle after start is accepted until DONE exits
done  output  1  one-cycle pulse when the last fill pair is accepted
addr_a  output  BitA  RAM_A read address
en_a  output  1  RAM_A read enable
dout_a  input  9  RAM_A read data, valid the cycle after en_a
addr_b  output  BitB  RAM_B read address
en_b  output  1  RAM_B read enable
dout_b  input  9  RAM_B read data, valid the cycle after en_b
pair_valid  output  1  fill pair available
pair_ready  input  1  fill datapath accepts pair
pair_i  output  BitA  row index of presented pair
pair_j  output  BitB  column index of presented pair
char_a  output  9  A[pair_i]; shared with the traceback port
char_b  output  9  B[pair_j]; shared with the traceback port
tb_req  input  1  traceback read request (level, held until tb_ack)
tb_i  input  BitA  traceback row address, sampled when the request is accepted
tb_j  input  BitB  traceback column address, sampled when the request is accepted
tb_ack  output  1  one-cycle pulse; char_a/char_b hold A[tb_i], B[tb_j]

Behaviour:
- Reset (rst=0 at an edge): state=IDLE; i=j=0; all outputs 0, including char_a and char_b. Reset applies mid-scan or mid-traceback with no residue; a pending tb_req is re-arbitrated after reset is released.
- States: IDLE, ISSUE, CAPTURE, PRESENT, DONE, TB_ISSUE, TB_CAPTURE, TB_ACK.
- IDLE:
  - start=1 -> i=0, j=0, go to ISSUE.
  - Otherwise tb_req=1 -> latch tb_i/tb_j, go to TB_ISSUE.
  - start and tb_req in the same cycle: start wins; tb_req stays pending.
- ISSUE:
  - en_a=en_b=1; addr_a=i, addr_b=j.
  - en_a/en_b are high only in ISSUE and TB_ISSUE; addresses are 0 in all other states.
  - Next state: CAPTURE.
- CAPTURE: char_a<=dout_a, char_b<=dout_b; go to PRESENT.
- PRESENT:
  - pair_valid=1, pair_i=i, pair_j=j. char_a/char_b are stable while pair_valid is high.
  - pair_ready=0: stay.
  - pair_ready=1 and (i,j)=(N-1,M-1): go to DONE.
  - pair_ready=1 and j=M-1: j=0, i=i+1, go to ISSUE.
  - pair_ready=1 otherwise: j=j+1, go to ISSUE.
- Throughput: one pair per 3 cycles with pair_ready tied high; N*M pairs per scan.
- DONE: done=1 for exactly one cycle, then IDLE.
- busy=1 in ISSUE, CAPTURE, PRESENT and DONE.
- start outside IDLE is ignored, not queued.
- tb_req is never served during a scan; it waits for IDLE.
- TB_ISSUE: en_a=en_b=1, addr_a=latched tb_i, addr_b=latched tb_j; go to TB_CAPTURE.
- TB_CAPTURE: latch dout_a/dout_b into char_a/char_b; go to TB_ACK.
- TB_ACK: tb_ack=1 for one cycle; go to IDLE.
  - The requester must drop tb_req in the cycle after tb_ack, or a new read is issued.
  - tb_ack follows the accepting edge by 3 cycles.
- pair_valid=0 and tb_ack=0 at all times outside their own states.
- Indices never exceed N-1 / M-1; there is no wrap past the last cell.
- Out-of-range tb_i/tb_j are not checked; the requester guarantees range.

Test Plan:
- N=5, M=4, A="CACTG" (43,41,43,54,47 hex), B="GATC" (47,41,54,43 hex), pair_ready=1, pulse start -> 20 pairs in order (0,0)..(4,3). First pair_valid appears 2 cycles after ISSUE with char_a=043, char_b=047. Last pair (4,3) has char_a=047, char_b=043. done pulses once, 60 cycles after leaving IDLE.
- Same setup, pair_ready low for 5 cycles at pair (1,2) -> pair_valid, pair_i=1, pair_j=2, char_a=041, char_b=054 stay constant. en_a/en_b stay low meanwhile. Scan resumes at (1,3) and wraps to (2,0).
- After done, tb_req=1 with tb_i=3, tb_j=1 -> tb_ack exactly one cycle, 3 cycles after acceptance, with char_a=054, char_b=041.
- start and tb_req (tb_i=0, tb_j=0) asserted together in IDLE -> full scan runs first. The traceback read is served right after DONE/IDLE and returns char_a=043, char_b=047.
- rst=0 at pair (2,1) -> next edge: IDLE, busy/pair_valid/en_a/en_b/char_a/char_b = 0. A new start rescans from (0,0).
- start pulsed again mid-scan at pair (3,0) -> ignored. Exactly 20 pairs total and a single done pulse.
